// File: rtl/f16_fmac_pkg.sv
// rtl/f16_fmac_pkg.sv - shared f16 constants and dot-product sequencer state encoding
package f16_fmac_pkg;

    localparam logic [15:0] F16_ZERO = 16'h0000;
    localparam logic [15:0] F16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/f16_fmac_dot_ctrl_if.sv
// rtl/f16_fmac_dot_ctrl_if.sv - operand and result valid/ready streams of the dot-product engine
interface f16_fmac_dot_ctrl_if #(
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_x;
    logic [15:0]      in_y;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [CNT_W-1:0] out_terms;
    logic             out_trunc;

    modport master (
        output in_valid, in_x, in_y, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_terms, out_trunc
    );

    modport slave (
        input  in_valid, in_x, in_y, in_last, out_ready,
        output in_ready, out_valid, out_result, out_terms, out_trunc
    );
endinterface

// File: rtl/f16_fmac_normal_no_grs.sv
// rtl/f16_fmac_normal_no_grs.sv - combinational f16 x*y+z, normal operands only, truncating alignment
module f16_fmac_normal_no_grs (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_z,
    output logic [15:0] o_result
);
    logic              w_pz, w_zz, w_ps, w_rs, w_found;
    logic [21:0]       w_pm, w_zm;
    logic signed [7:0] w_pe, w_ze, w_eb, w_diff, w_re;
    logic [22:0]       w_ma, w_mb, w_sum, w_norm;
    logic [4:0]        w_lead;

    // exponent 0 is treated as zero; zero operands get a sentinel exponent so they never win alignment
    assign w_pz = (i_x[14:10] == 5'd0) || (i_y[14:10] == 5'd0);
    assign w_zz = (i_z[14:10] == 5'd0);
    assign w_ps = i_x[15] ^ i_y[15];
    assign w_pm = w_pz ? 22'd0 : ({1'b1, i_x[9:0]} * {1'b1, i_y[9:0]});
    assign w_zm = w_zz ? 22'd0 : {1'b0, 1'b1, i_z[9:0], 10'd0};
    assign w_pe = w_pz ? -8'sd40
                       : ($signed({3'b000, i_x[14:10]}) + $signed({3'b000, i_y[14:10]}) - 8'sd15);
    assign w_ze = w_zz ? -8'sd40 : $signed({3'b000, i_z[14:10]});

    function automatic logic [22:0] shr(input logic [22:0] m, input logic signed [7:0] d);
        return (d > 8'sd22) ? 23'd0 : (m >> d[4:0]);
    endfunction

    always_comb begin
        w_eb   = w_pe;
        w_diff = 8'sd0;
        w_ma   = {1'b0, w_pm};
        w_mb   = {1'b0, w_zm};
        if (w_pe >= w_ze) begin
            w_diff = w_pe - w_ze;
            w_mb   = shr({1'b0, w_zm}, w_diff);
        end else begin
            w_eb   = w_ze;
            w_diff = w_ze - w_pe;
            w_ma   = shr({1'b0, w_pm}, w_diff);
        end

        w_rs  = w_ps;
        w_sum = w_ma + w_mb;
        if (w_ps != i_z[15]) begin
            if (w_ma >= w_mb) begin
                w_sum = w_ma - w_mb;
            end else begin
                w_sum = w_mb - w_ma;
                w_rs  = i_z[15];
            end
        end

        w_lead  = 5'd0;
        w_found = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (w_sum[i]) begin
                w_lead  = 5'(i);
                w_found = 1'b1;
            end
        end
        w_norm = w_sum << (5'd22 - w_lead);
        w_re   = w_eb + $signed({3'b000, w_lead}) - 8'sd20;

        if (!w_found || w_re <= 8'sd0) begin
            o_result = 16'h0000;
        end else if (w_re >= 8'sd31) begin
            o_result = {w_rs, 5'h1F, 10'd0};
        end else begin
            o_result = {w_rs, w_re[4:0], w_norm[21:12]};
        end
    end
endmodule

// File: rtl/f16_fmac_dot_ctrl.sv
// rtl/f16_fmac_dot_ctrl.sv - streaming f16 dot-product sequencer around one FMAC
// F16_DOT_OPREG_EN adds operand registers and a CALC state (1 beat per 2 cycles).
module f16_fmac_dot_ctrl
    import f16_fmac_pkg::*;
#(
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] acc_init,
    output logic        busy,
    f16_fmac_dot_ctrl_if.slave bus
);
    state_t           r_state, w_next;
    logic [15:0]      r_acc, w_fmac, w_x, w_y;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic             r_trunc, w_hs, w_close;

    assign w_hs      = (r_state == ST_ACC) && bus.in_valid;
    assign w_cnt_inc = r_cnt + 1'b1;
    // in_last wins over the limit, so trunc is only set when the count alone closed the sum
    assign w_close   = bus.in_last || (w_cnt_inc == CNT_W'(MAX_TERMS));

`ifdef F16_DOT_OPREG_EN
    logic [15:0] r_op_x, r_op_y;
    logic        r_op_close, r_op_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_x     <= F16_ZERO;
            r_op_y     <= F16_ZERO;
            r_op_close <= 1'b0;
            r_op_last  <= 1'b0;
        end else if (w_hs) begin
            r_op_x     <= bus.in_x;
            r_op_y     <= bus.in_y;
            r_op_close <= w_close;
            r_op_last  <= bus.in_last;
        end
    end
    assign w_x = r_op_x;
    assign w_y = r_op_y;
`else
    assign w_x = bus.in_x;
    assign w_y = bus.in_y;
`endif

    f16_fmac_normal_no_grs u_fmac (
        .i_x      (w_x),
        .i_y      (w_y),
        .i_z      (r_acc),
        .o_result (w_fmac)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_ACC;
`ifdef F16_DOT_OPREG_EN
            ST_ACC:  if (bus.in_valid) w_next = ST_CALC;
            ST_CALC: w_next = r_op_close ? ST_DONE : ST_ACC;
`else
            ST_ACC:  if (bus.in_valid && w_close) w_next = ST_DONE;
`endif
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_result = F16_ZERO;
        bus.out_terms  = '0;
        bus.out_trunc  = 1'b0;
        busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_ACC: bus.in_ready = 1'b1;
            ST_DONE: begin
                bus.out_valid  = 1'b1;
                bus.out_result = r_acc;
                bus.out_terms  = r_cnt;
                bus.out_trunc  = r_trunc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= F16_ZERO;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_acc   <= acc_init;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
`ifdef F16_DOT_OPREG_EN
        end else if (r_state == ST_CALC) begin
            r_acc <= w_fmac;
            r_cnt <= w_cnt_inc;
            if (r_op_close) r_trunc <= ~r_op_last;
`else
        end else if (w_hs) begin
            r_acc <= w_fmac;
            r_cnt <= w_cnt_inc;
            if (w_close) r_trunc <= ~bus.in_last;
`endif
        end
    end
endmodule

// File: tb/tb_f16_fmac_dot_ctrl.sv
// tb/tb_f16_fmac_dot_ctrl.sv - randomized self-checking bench against a real-arithmetic dot-product model
module tb_f16_fmac_dot_ctrl;
    localparam int MAXT = 4;
    localparam int CW   = $clog2(MAXT + 1);
`ifdef F16_DOT_OPREG_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] acc_init = 16'h0000;
    logic        busy;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] bx [8];
    logic [15:0] by [8];
    logic [15:0] vals [8] = '{16'h3800, 16'h3C00, 16'h3E00, 16'h4000,
                              16'h4200, 16'h4400, 16'hBC00, 16'hC000};

    f16_fmac_dot_ctrl_if #(.CNT_W(CW)) bus ();

    f16_fmac_dot_ctrl #(.MAX_TERMS(MAXT), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .acc_init (acc_init),
        .busy     (busy),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2f(input real v);
        real  a;
        int   e;
        int   f;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f = int'((a - 1.0) * 1024.0);
        return {s, 5'(e + 15), 10'(f)};
    endfunction

    function automatic logic [15:0] dot_model(input logic [15:0] init, input int k);
        real acc;
        acc = f2r(init);
        for (int i = 0; i < k; i++) acc = acc + f2r(bx[i]) * f2r(by[i]);
        return r2f(acc);
    endfunction

    // start one dot product, stream its beats, then check the result and the DONE hand-off
    task automatic run_dot(input logic [15:0] init, input int n, input bit use_last,
                           input bit toggle, input int hold, input bit pulse_start);
        int          k;
        int          lat;
        bit          ok;
        logic [15:0] exp_r;
        k     = (use_last && n <= MAXT) ? n : MAXT;
        exp_r = dot_model(init, k);
        bus.out_ready = (hold == 0);
        start = 1'b1;
        acc_init = init;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (toggle) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_x     = bx[i];
            bus.in_y     = by[i];
            bus.in_last  = use_last && (i == n - 1);
            ok = 1'b0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                check("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
            else lat++;
        end
        check("out_valid_seen", 32'(ok), 32'd1);
        check("latency", 32'(lat), 32'(EXP_LAT));
        check("out_result", 32'(bus.out_result), 32'(exp_r));
        check("out_terms", 32'(bus.out_terms), 32'(k));
        check("out_trunc", 32'(bus.out_trunc), 32'(!(use_last && n <= MAXT)));
        check("in_ready_done", 32'(bus.in_ready), 32'd0);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                start = pulse_start && (h == 1);
                @(negedge clk);
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_result", 32'(bus.out_result), 32'(exp_r));
                check("hold_terms", 32'(bus.out_terms), 32'(k));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_busy", 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_after", {30'd0, busy, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = 16'h0000;
        bus.in_y      = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("reset_outputs", 32'({bus.in_ready, bus.out_valid, busy, bus.out_trunc,
                                    bus.out_terms, bus.out_result}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        bx[0] = 16'h3C00; by[0] = 16'h4000;
        bx[1] = 16'h4000; by[1] = 16'h4000;
        run_dot(16'h0000, 2, 1'b1, 1'b0, 0, 1'b0);

        bx[0] = 16'h4200; by[0] = 16'h4200;
        run_dot(16'h3C00, 1, 1'b1, 1'b0, 0, 1'b0);

        bx[0] = 16'h4000; by[0] = 16'h4200;
        bx[1] = 16'h3800; by[1] = 16'h4400;
        run_dot(16'h3E00, 2, 1'b1, 1'b0, 5, 1'b1);

        for (int i = 0; i < 8; i++) begin bx[i] = 16'h3C00; by[i] = 16'h3C00; end
        run_dot(16'h0000, 5, 1'b0, 1'b0, 0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x     = 16'h3C00;
        bus.in_y     = 16'h3C00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fifth_beat_blocked", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        run_dot(16'h0000, 4, 1'b1, 1'b0, 0, 1'b0);

        start = 1'b1;
        acc_init = 16'h4400;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x = 16'h4000;
        bus.in_y = 16'h4000;
        bus.in_last = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'({bus.in_ready, bus.out_valid, busy, bus.out_trunc,
                                  bus.out_terms, bus.out_result}), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bx[0] = 16'h3800; by[0] = 16'h4000;
        run_dot(16'h0000, 1, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin bx[i] = 16'h4000; by[i] = 16'h3800; end
        run_dot(16'h0000, 3, 1'b1, 1'b1, 0, 1'b0);

        bx[0] = 16'hC000; by[0] = 16'h3C00;
        run_dot(16'h4400, 1, 1'b1, 1'b0, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            bit use_last;
            int n;
            use_last = ($urandom_range(0, 3) != 0);
            n = use_last ? int'($urandom_range(1, MAXT)) : MAXT;
            for (int i = 0; i < MAXT; i++) begin
                bx[i] = vals[$urandom_range(0, 7)];
                by[i] = vals[$urandom_range(0, 7)];
            end
            run_dot(vals[$urandom_range(0, 5)], n, use_last, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
